// File: rtl/inst_issue_queue.sv
// Instruction issue queue feeding the systolic array.
// A FIFO holds host instructions; a small FSM hands them one at a time to
// the array, using the idle_flag/flag handshake, and watches each handshake
// phase with a down-counting timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | nothing in flight; issue the head when queued and array idle
// ST_ISSUE  | init_inst_pulse held high until the array drops idle_flag
// ST_WAIT   | array working; wait for flag to signal completion
module inst_issue_queue #(
  parameter int INST_BITS = 40,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT   = 65535
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [INST_BITS-1:0]     in_inst,
  output logic                     in_ready,
  output logic                     init_inst_pulse,
  output logic [INST_BITS-1:0]     instruction,
  input  logic                     idle_flag,
  input  logic                     flag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done_pulse,
  output logic                     err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Timer is loaded with TIMEOUT-1 and expires when it reads zero.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

  logic [INST_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [1:0]           state;
  logic [TW-1:0]        timer;
  logic                 full;
  logic                 push;
  logic                 pop;

  assign full     = (count == CW'(DEPTH));
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  // Only IDLE may pop, so a single instruction is ever in flight.
  assign pop      = (state == ST_IDLE) && (count != '0) && idle_flag;
  assign busy     = (state != ST_IDLE);

  // Queue storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_inst;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue/handshake FSM with per-phase timeout down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      timer           <= '0;
      init_inst_pulse <= 1'b0;
      instruction     <= '0;
      done_pulse      <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state           <= ST_ISSUE;
            instruction     <= mem[rd_ptr];
            init_inst_pulse <= 1'b1;
            timer           <= TIMER_LOAD;
          end
        end
        ST_ISSUE: begin
          // A real accept wins over an expiry landing on the same edge.
          if (!idle_flag) begin
            state           <= ST_WAIT;
            init_inst_pulse <= 1'b0;
            timer           <= TIMER_LOAD;
          end else if (timer == '0) begin
            state           <= ST_IDLE;
            init_inst_pulse <= 1'b0;
            err_timeout     <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_WAIT: begin
          if (flag) begin
            state      <= ST_IDLE;
            done_pulse <= 1'b1;
          end else if (timer == '0) begin
            // Instruction is abandoned: no completion is reported.
            state       <= ST_IDLE;
            err_timeout <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state           <= ST_IDLE;
          init_inst_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Bench for inst_issue_queue: table of single-instruction handshakes, then
// hand sequences for full queue, full-with-completion, timeout and reset.
module tb_inst_issue_queue;

  localparam int INST_BITS = 40;
  localparam int DEPTH     = 16;
  localparam int TIMEOUT   = 16;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic [INST_BITS-1:0] in_inst = '0;
  logic                 idle_flag = 1'b0;
  logic                 flag = 1'b0;
  logic                 in_ready;
  logic                 init_inst_pulse;
  logic [INST_BITS-1:0] instruction;
  logic [CW-1:0]        count;
  logic                 busy;
  logic                 done_pulse;
  logic                 err_timeout;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int issue_cnt = 0;
  logic [INST_BITS-1:0] exp_q[$];

  typedef struct {
    logic [INST_BITS-1:0] inst;
    int                   drop_dly;
    int                   done_dly;
  } vec_t;
  vec_t vecs[4];

  inst_issue_queue #(
    .INST_BITS(INST_BITS),
    .DEPTH    (DEPTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_inst        (in_inst),
    .in_ready       (in_ready),
    .init_inst_pulse(init_inst_pulse),
    .instruction    (instruction),
    .idle_flag      (idle_flag),
    .flag           (flag),
    .count          (count),
    .busy           (busy),
    .done_pulse     (done_pulse),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [INST_BITS-1:0] word(input int i);
    return {8'(i + 1), 16'(i * 7 + 3), 16'(16'hBEEF ^ i)};
  endfunction

  task automatic push_word(input logic [INST_BITS-1:0] w, input bit accept);
    in_valid = 1'b1;
    in_inst  = w;
    tick();
    in_valid = 1'b0;
    if (accept) exp_q.push_back(w);
  endtask

  // Array model: accept drop_dly cycles after the pulse, complete done_dly later.
  task automatic serve(input int drop_dly, input int done_dly);
    int n;
    n = 0;
    while (!init_inst_pulse && n < 40) begin
      tick();
      n++;
    end
    chk("serve_issue_seen", 64'(init_inst_pulse), 64'd1);
    repeat (drop_dly) tick();
    idle_flag = 1'b0;
    tick();
    chk("pulse_clear_on_accept", 64'(init_inst_pulse), 64'd0);
    chk("busy_wait_done", 64'(busy), 64'd1);
    repeat (done_dly - 1) tick();
    flag = 1'b1;
    tick();
    flag = 1'b0;
    chk("done_pulse_high", 64'(done_pulse), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
    idle_flag = 1'b1;
    tick();
    chk("done_pulse_one_cycle", 64'(done_pulse), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pulse"}, 64'(init_inst_pulse), 64'd0);
    chk({tag, "_instruction"}, 64'(instruction), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done_pulse), 64'd0);
    chk({tag, "_err"}, 64'(err_timeout), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Scoreboard: every rising init_inst_pulse must carry the oldest expected word.
  initial begin
    logic prev;
    logic [INST_BITS-1:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b0;
      end else begin
        if (init_inst_pulse && !prev) begin
          issue_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: got %0h, expected no issue", instruction);
          end else begin
            e = exp_q.pop_front();
            chk("issue_order", 64'(instruction), 64'(e));
          end
        end
        if (done_pulse) done_cnt++;
        prev = init_inst_pulse;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int i0;
    vecs[0] = '{40'h00_0000_0001, 3, 10};
    vecs[1] = '{40'hFF_FFFF_FFFF, 0, 1};
    vecs[2] = '{40'hA5_5A5A_A5A5, 1, 4};
    vecs[3] = '{40'h12_3456_789A, 5, 2};

    #12;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    idle_flag = 1'b1;
    chk("release_in_ready", 64'(in_ready), 64'd1);

    // Single-instruction handshakes, one-cycle issue latency each.
    foreach (vecs[k]) begin
      d0 = done_cnt;
      push_word(vecs[k].inst, 1'b1);
      chk("count_after_push", 64'(count), 64'd1);
      chk("no_pulse_on_push_edge", 64'(init_inst_pulse), 64'd0);
      tick();
      chk("pulse_latency", 64'(init_inst_pulse), 64'd1);
      chk("count_after_pop", 64'(count), 64'd0);
      chk("busy_in_issue", 64'(busy), 64'd1);
      chk("instruction_word", 64'(instruction), 64'(vecs[k].inst));
      serve(vecs[k].drop_dly, vecs[k].done_dly);
      chk("one_done_per_inst", 64'(done_cnt), 64'(d0 + 1));
      chk("idle_after_done", 64'(busy), 64'd0);
    end

    // Fill the queue with the array busy; 17th word must be refused.
    idle_flag = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk("in_ready_while_filling", 64'(in_ready), 64'(i < DEPTH));
      push_word(word(i), i < DEPTH);
    end
    chk("count_full", 64'(count), 64'(DEPTH));
    chk("in_ready_full", 64'(in_ready), 64'd0);

    idle_flag = 1'b1;
    tick();
    chk("issue_from_full", 64'(init_inst_pulse), 64'd1);
    chk("count_after_issue", 64'(count), 64'(DEPTH - 1));
    chk("in_ready_after_issue", 64'(in_ready), 64'd1);
    idle_flag = 1'b0;
    tick();
    chk("accept_clears_pulse", 64'(init_inst_pulse), 64'd0);
    push_word(word(17), 1'b1);
    chk("count_refilled", 64'(count), 64'(DEPTH));
    chk("in_ready_refilled", 64'(in_ready), 64'd0);

    // Completion and a push offered on the same edge while full.
    flag     = 1'b1;
    in_valid = 1'b1;
    in_inst  = word(99);
    tick();
    flag     = 1'b0;
    in_valid = 1'b0;
    chk("count_full_complete_push", 64'(count), 64'(DEPTH));
    chk("done_full_complete", 64'(done_pulse), 64'd1);
    chk("busy_full_complete", 64'(busy), 64'd0);
    idle_flag = 1'b1;
    tick();
    chk("next_issue_oldest", 64'(instruction), 64'(word(1)));
    chk("count_after_oldest", 64'(count), 64'(DEPTH - 1));
    for (int i = 0; i < DEPTH; i++) serve(1, 2);
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);

    // Array never accepts: ISSUE expires after TIMEOUT cycles.
    idle_flag = 1'b0;
    push_word(40'hDE_AD00_0001, 1'b1);
    push_word(40'hDE_AD00_0002, 1'b1);
    idle_flag = 1'b1;
    d0 = done_cnt;
    tick();
    chk("timeout_issue", 64'(init_inst_pulse), 64'd1);
    repeat (TIMEOUT - 1) tick();
    chk("timeout_not_yet", 64'(err_timeout), 64'd0);
    chk("timeout_pulse_held", 64'(init_inst_pulse), 64'd1);
    tick();
    chk("timeout_err_set", 64'(err_timeout), 64'd1);
    chk("timeout_pulse_cleared", 64'(init_inst_pulse), 64'd0);
    chk("timeout_busy", 64'(busy), 64'd0);
    tick();
    chk("timeout_next_issues", 64'(init_inst_pulse), 64'd1);
    chk("timeout_next_word", 64'(instruction), 64'h00DE_AD00_0002);
    chk("timeout_no_done", 64'(done_cnt), 64'(d0));
    serve(2, 3);
    chk("timeout_sticky", 64'(err_timeout), 64'd1);

    // Reset while an instruction is in WAIT with five more queued.
    idle_flag = 1'b0;
    for (int i = 0; i < 6; i++) push_word(word(40 + i), 1'b1);
    idle_flag = 1'b1;
    tick();
    idle_flag = 1'b0;
    tick();
    chk("pre_reset_count", 64'(count), 64'd5);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midflight_reset");
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    idle_flag = 1'b1;
    i0 = issue_cnt;
    d0 = done_cnt;
    repeat (20) tick();
    chk("post_reset_no_issue", 64'(issue_cnt), 64'(i0));
    chk("post_reset_no_done", 64'(done_cnt), 64'(d0));
    chk("post_reset_count", 64'(count), 64'd0);
    chk("post_reset_err", 64'(err_timeout), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
